dmem_arbiter: RTL and testbench

- Shares the single-port data RAM (word-addressed, 1-cycle synchronous read) between two requesters.
- Port 0 is the MEM pipeline stage, for loads and stores. Port 1 is the program/debug loader.
- Sequences every RAM access through a small FSM, so RAM write enable is asserted for exactly one clock per store.
- Provides a valid/ready request handshake, a read-response strobe and a pipeline stall output.

---
 rtl/dmem_arbiter_pkg.sv | 15 +
 rtl/dmem_arbiter_rr_arb2.sv | 40 ++++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared state encoding and constants for the data-RAM arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  localparam int WORD_SHIFT = 2;

  localparam logic PORT_MEM = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way round-robin grant with optional fixed port-0 priority
module rr_arb2
  import dmem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt_idx
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt_idx = ~req[0];
    if (FIXED_PRIO == 0 && (&req)) begin
      gnt_idx = ~last_grant_q;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = gnt_idx;
    end
  end

  // Reset to the loader port so the pipeline wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= PORT_LDR;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares a single-port synchronous data RAM between the MEM stage and the loader
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [31:0]       p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [31:0]       p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              stall,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_e            state_q, state_d;
  logic              port_q, port_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        req_vec;
  logic              gnt_idx;
  logic              arb_update;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        ready_v;
  logic [1:0]        err_v;
  logic [1:0]        rvalid_v;
  logic              unused_addr_bits;

  assign req_vec = {p1_req, p0_req};

  rr_arb2 #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_rr_arb2 (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .update (arb_update),
    .gnt_idx(gnt_idx)
  );

  assign sel_we    = gnt_idx ? p1_we    : p0_we;
  assign sel_addr  = gnt_idx ? p1_addr  : p0_addr;
  assign sel_wdata = gnt_idx ? p1_wdata : p0_wdata;

  // Bits above the RAM word index are dropped so accesses wrap.
  assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p1_addr[31:ADDR_W+2]};

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ready_v    = 2'b00;
    err_v      = 2'b00;
    rvalid_v   = 2'b00;
    arb_update = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_vec) begin
          arb_update       = 1'b1;
          ready_v[gnt_idx] = 1'b1;
          if (sel_addr[1:0] == 2'b00) begin
            ram_addr_d = sel_addr[ADDR_W+1:WORD_SHIFT];
            ram_din_d  = sel_wdata;
            ram_we_d   = sel_we;
            port_d     = gnt_idx;
            state_d    = ACCESS;
          end else begin
            err_v[gnt_idx] = 1'b1;
          end
        end
      end
      ACCESS: begin
        state_d = ram_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        rvalid_v[port_q] = 1'b1;
        if (port_q == PORT_LDR) begin
          rdata1_d = ram_dout;
        end else begin
          rdata0_d = ram_dout;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_MEM;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // Strobes are masked by reset so an aborted transaction shows nothing.
  assign p0_ready  = ready_v[0]  & rst;
  assign p1_ready  = ready_v[1]  & rst;
  assign p0_err    = err_v[0]    & rst;
  assign p1_err    = err_v[1]    & rst;
  assign p0_rvalid = rvalid_v[0] & rst;
  assign p1_rvalid = rvalid_v[1] & rst;

  assign p0_rdata = p0_rvalid ? ram_dout : rdata0_q;
  assign p1_rdata = p1_rvalid ? ram_dout : rdata1_q;

  assign stall    = p0_req & ~p0_ready;
  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [31:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic        p0_ready, p0_rvalid, p0_err, p1_ready, p1_rvalid, p1_err, stall;
  logic [31:0] p0_rdata, p1_rdata;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  logic        fp_p0_req = 0, fp_p1_req = 0;
  logic        fp_p0_ready, fp_p0_rvalid, fp_p0_err, fp_p1_ready, fp_p1_rvalid, fp_p1_err, fp_stall;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_ram_din;
  logic        fp_ram_we;
  logic [13:0] fp_ram_addr;
  logic [31:0] fp_ram_dout = 32'h0;
  logic [31:0] fp_zero = 32'h0;

  logic [31:0] mem [0:16383];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .stall(stall), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  dmem_arbiter #(.ADDR_W(14), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .p0_req(fp_p0_req), .p0_we(1'b0), .p0_addr(fp_zero), .p0_wdata(fp_zero),
    .p0_ready(fp_p0_ready), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata), .p0_err(fp_p0_err),
    .p1_req(fp_p1_req), .p1_we(1'b0), .p1_addr(fp_zero), .p1_wdata(fp_zero),
    .p1_ready(fp_p1_ready), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata), .p1_err(fp_p1_err),
    .stall(fp_stall), .ram_we(fp_ram_we), .ram_addr(fp_ram_addr), .ram_din(fp_ram_din),
    .ram_dout(fp_ram_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_din", ram_din, 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);

    // single store
    next_cycle();
    set_p0(1, 1, 32'h0000_0010, 32'hDEAD_BEEF);
    @(negedge clk);
    check("st_p0_ready", 32'(p0_ready), 32'd1);
    check("st_p0_err", 32'(p0_err), 32'd0);
    check("st_stall", 32'(stall), 32'd0);
    check("st_c0_ram_we", 32'(ram_we), 32'd0);
    next_cycle();
    set_p0(0, 0, 0, 0);
    @(negedge clk);
    check("st_c1_ram_we", 32'(ram_we), 32'd1);
    check("st_c1_ram_addr", 32'(ram_addr), 32'd4);
    check("st_c1_ram_din", ram_din, 32'hDEAD_BEEF);
    next_cycle();
    @(negedge clk);
    check("st_c2_ram_we", 32'(ram_we), 32'd0);
    check("st_c2_state", 32'(dut.state_q), 32'd0);

    // p1 store wins (last grant was p0) while p0 load stalls, then p0 loads back
    next_cycle();
    set_p0(1, 0, 32'h0000_0010, 0);
    set_p1(1, 1, 32'h0000_0020, 32'h1111_2222);
    @(negedge clk);
    check("lb_p1_ready", 32'(p1_ready), 32'd1);
    check("lb_p0_ready_wait", 32'(p0_ready), 32'd0);
    check("lb_stall_a", 32'(stall), 32'd1);
    next_cycle();
    set_p1(0, 0, 0, 0);
    @(negedge clk);
    check("lb_stall_b", 32'(stall), 32'd1);
    check("lb_p1_ram_we", 32'(ram_we), 32'd1);
    check("lb_p1_ram_addr", 32'(ram_addr), 32'd8);
    next_cycle();
    @(negedge clk);
    check("lb_p0_ready", 32'(p0_ready), 32'd1);
    check("lb_stall_c", 32'(stall), 32'd0);
    next_cycle();
    set_p0(0, 0, 0, 0);
    @(negedge clk);
    check("lb_rvalid_early", 32'(p0_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("lb_p0_rvalid", 32'(p0_rvalid), 32'd1);
    check("lb_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
    check("lb_p1_rvalid", 32'(p1_rvalid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("lb_rvalid_pulse", 32'(p0_rvalid), 32'd0);
    check("lb_rdata_held", p0_rdata, 32'hDEAD_BEEF);

    // round-robin contention from reset
    do_reset();
    set_p0(1, 0, 32'h0000_0010, 0);
    set_p1(1, 0, 32'h0000_0020, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("rr_p0_ready_%0d", k), 32'(p0_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 0)));
      check($sformatf("rr_p1_ready_%0d", k), 32'(p1_ready), 32'((k % 3 == 0) && ((k / 3) % 2 == 1)));
      if (k % 3 == 2) begin
        if ((k / 3) % 2 == 0) begin
          check($sformatf("rr_p0_rvalid_%0d", k), 32'(p0_rvalid), 32'd1);
          check($sformatf("rr_p0_rdata_%0d", k), p0_rdata, 32'hDEAD_BEEF);
        end else begin
          check($sformatf("rr_p1_rvalid_%0d", k), 32'(p1_rvalid), 32'd1);
          check($sformatf("rr_p1_rdata_%0d", k), p1_rdata, 32'h1111_2222);
        end
      end
      next_cycle();
    end
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0);

    // misaligned p1 store
    set_p1(1, 1, 32'h0000_0006, 32'h5555_AAAA);
    @(negedge clk);
    check("mis_p1_ready", 32'(p1_ready), 32'd1);
    check("mis_p1_err", 32'(p1_err), 32'd1);
    check("mis_p0_ready", 32'(p0_ready), 32'd0);
    check("mis_p0_err", 32'(p0_err), 32'd0);
    next_cycle();
    set_p1(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("mis_ram_we_%0d", k), 32'(ram_we), 32'd0);
      check($sformatf("mis_state_%0d", k), 32'(dut.state_q), 32'd0);
      next_cycle();
    end

    // reset during RDWAIT of a p0 load
    set_p0(1, 0, 32'h0000_0020, 0);
    @(negedge clk);
    check("ro_p0_ready", 32'(p0_ready), 32'd1);
    next_cycle();
    set_p0(0, 0, 0, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    check("ro_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("ro_p0_rdata", p0_rdata, 32'd0);
    check("ro_ram_addr", 32'(ram_addr), 32'd0);
    check("ro_ram_din", ram_din, 32'd0);
    check("ro_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    check("ro_p0_rvalid_b", 32'(p0_rvalid), 32'd0);
    next_cycle();
    rst = 1'b1;
    set_p0(1, 0, 32'h0000_0010, 0);
    set_p1(1, 0, 32'h0000_0020, 0);
    @(negedge clk);
    check("ro_first_p0", 32'(p0_ready), 32'd1);
    check("ro_first_p1", 32'(p1_ready), 32'd0);
    next_cycle();
    set_p0(0, 0, 0, 0);
    set_p1(0, 0, 0, 0);
    repeat (2) next_cycle();

    // address wrap
    set_p0(1, 1, 32'h0001_0004, 32'hCAFE_F00D);
    @(negedge clk);
    check("wr_p0_ready", 32'(p0_ready), 32'd1);
    next_cycle();
    set_p0(0, 0, 0, 0);
    @(negedge clk);
    check("wr_ram_we", 32'(ram_we), 32'd1);
    check("wr_ram_addr", 32'(ram_addr), 32'd1);
    check("wr_ram_din", ram_din, 32'hCAFE_F00D);
    next_cycle();

    // fixed priority instance
    fp_p0_req = 1'b1;
    fp_p1_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check($sformatf("fp_p0_ready_%0d", k), 32'(fp_p0_ready), 32'(k % 3 == 0));
      check($sformatf("fp_p1_ready_%0d", k), 32'(fp_p1_ready), 32'd0);
      next_cycle();
    end
    fp_p0_req = 1'b0;
    @(negedge clk);
    check("fp_p1_after_drop", 32'(fp_p1_ready), 32'd1);
    next_cycle();
    fp_p1_req = 1'b0;
    repeat (3) next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
